// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// default geometry/latency and a small sizing helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'b00,
    DM_BUSY = 2'b01,
    DM_RESP = 2'b10
  } dm_state_e;

  localparam int unsigned DM_DEF_LATENCY   = 4;
  localparam int unsigned DM_DEF_NUM_WORDS = 16384;

  // Counter must hold LATENCY-1; a one-cycle latency still needs one bit.
  function automatic int unsigned dm_cnt_width(input int unsigned latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output req_valid, mem_read, mem_write, addr, din,
    input  req_ready, resp_valid, dout
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, din,
    output req_ready, resp_valid, dout
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Word-organised storage: synchronous write port, combinational read port.
// Contents are deliberately not reset.
module dmem_responder_array #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 16384
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(NUM_WORDS)-1:0] i_idx,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time,
// holds it for LATENCY cycles, then pulses resp_valid for one cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WORDS  = DM_DEF_NUM_WORDS,
  parameter int LATENCY    = DM_DEF_LATENCY
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = dm_cnt_width(LATENCY);

  dm_state_e             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_is_store;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_addr;

  // Byte offset and bits above the word index are dropped, so addresses alias.
  assign w_unused_addr = ^{bus.addr[ADDR_WIDTH-1:IDX_W+2], bus.addr[1:0]};

  assign w_ready  = (r_state != DM_BUSY);
  assign w_accept = bus.req_valid && w_ready && (bus.mem_read || bus.mem_write);
  assign w_commit = (r_state == DM_BUSY) && (r_cnt == '0);
  assign w_we     = w_commit && r_is_store;

  dmem_responder_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_din),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= DM_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_din        <= '0;
      r_is_store   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        DM_IDLE, DM_RESP: begin
          if (w_accept) begin
            r_idx      <= bus.addr[IDX_W+1:2];
            r_din      <= bus.din;
            // Read+write together is a store with no load data.
            r_is_store <= bus.mem_write;
            r_cnt      <= CNT_W'(LATENCY - 1);
            r_state    <= DM_BUSY;
          end else begin
            r_state    <= DM_IDLE;
          end
        end
        DM_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state      <= DM_RESP;
            r_resp_valid <= 1'b1;
            if (!r_is_store) begin
              r_dout <= w_rdata;
            end
          end
        end
        default: r_state <= DM_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.dout       = r_dout;

endmodule
